keypad_digit_capture: RTL

// Scans a 4x4 matrix keypad, synchronizes and debounces the column inputs, and

---
 rtl/keypad_digit_capture.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_digit_capture.sv
// keypad_digit_capture
// Scans a 4x4 active-low matrix keypad one row at a time, synchronizes and
// debounces the column returns, and keeps the two most recently accepted hex
// key codes. Each accepted press produces one capture and one key_strobe pulse.
// Release is debounced the same way, so hold time and contact bounce do not
// create extra captures.

module keypad_digit_capture #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] digit_0,
    output logic [3:0] digit_1,
    output logic       key_strobe,
    output logic       key_held
);

    // One counter serves both the row dwell and the press/release debounce,
    // so it is sized for the larger of the two limits.
    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    logic [CW-1:0] cnt;
    logic [3:0]    sync1;
    logic [3:0]    col_s;
    logic [1:0]    next_row;

    assign next_row = row_idx + 2'd1;

    // Saturating increment: the counter holds at its maximum and never wraps.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == CNT_SAT) begin
            return v;
        end else begin
            return v + CW'(1);
        end
    endfunction

    // Active-low one-hot row drive pattern for a row index.
    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        case (idx)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1101;
            2'd2:    return 4'b1011;
            2'd3:    return 4'b0111;
            default: return 4'b1110;
        endcase
    endfunction

    // True when exactly one column is pulled low.
    function automatic logic single_low(input logic [3:0] cols);
        case (cols)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Index of the single low column (only meaningful when single_low is true).
    function automatic logic [1:0] low_index(input logic [3:0] cols);
        case (cols)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Keypad legend: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = E 0 F D.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: return 4'h1;
            4'b00_01: return 4'h2;
            4'b00_10: return 4'h3;
            4'b00_11: return 4'hA;
            4'b01_00: return 4'h4;
            4'b01_01: return 4'h5;
            4'b01_10: return 4'h6;
            4'b01_11: return 4'hB;
            4'b10_00: return 4'h7;
            4'b10_01: return 4'h8;
            4'b10_10: return 4'h9;
            4'b10_11: return 4'hC;
            4'b11_00: return 4'hE;
            4'b11_01: return 4'h0;
            4'b11_10: return 4'hF;
            4'b11_11: return 4'hD;
            default:  return 4'h0;
        endcase
    endfunction

    // Two-flop synchronizer bringing the asynchronous columns into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 4'b1111;
            col_s <= 4'b1111;
        end else begin
            sync1 <= col_n;
            col_s <= sync1;
        end
    end

    // Scan / debounce / held / release state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SCAN;
            row_idx    <= 2'd0;
            row_n      <= 4'b1110;
            col_idx    <= 2'd0;
            cnt        <= '0;
            digit_0    <= 4'h0;
            digit_1    <= 4'h0;
            key_strobe <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            case (state)
                SCAN: begin
                    if (cnt >= DWELL_LAST) begin
                        cnt <= '0;
                        if (single_low(col_s)) begin
                            // Freeze the row and start qualifying this column.
                            col_idx <= low_index(col_s);
                            state   <= DEBOUNCE;
                        end else begin
                            // No key, or an ambiguous multi-key pattern: move on.
                            row_idx <= next_row;
                            row_n   <= row_drive(next_row);
                        end
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                DEBOUNCE: begin
                    if (!col_s[col_idx]) begin
                        if (cnt >= DB_LAST) begin
                            digit_1    <= digit_0;
                            digit_0    <= key_code(row_idx, col_idx);
                            key_strobe <= 1'b1;
                            key_held   <= 1'b1;
                            cnt        <= '0;
                            state      <= HELD;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end else begin
                        // Bounce or glitch: give up and continue with the next row.
                        cnt     <= '0;
                        row_idx <= next_row;
                        row_n   <= row_drive(next_row);
                        state   <= SCAN;
                    end
                end
                HELD: begin
                    // Only the latched column matters; other keys are ignored.
                    if (col_s[col_idx]) begin
                        cnt   <= CW'(1);
                        state <= RELEASE;
                    end else begin
                        cnt <= '0;
                    end
                end
                RELEASE: begin
                    if (col_s[col_idx]) begin
                        if (cnt >= DB_LAST) begin
                            key_held <= 1'b0;
                            cnt      <= '0;
                            row_idx  <= next_row;
                            row_n    <= row_drive(next_row);
                            state    <= SCAN;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end else begin
                        cnt   <= '0;
                        state <= HELD;
                    end
                end
                default: begin
                    state    <= SCAN;
                    row_idx  <= 2'd0;
                    row_n    <= 4'b1110;
                    cnt      <= '0;
                    key_held <= 1'b0;
                end
            endcase
        end
    end

endmodule
